// File: rtl/ipl_pkg.sv
// Shared constants and phase encoding for the IPL Wishbone word mover.
package ipl_pkg;

  localparam logic [15:0] IPL_READ_ADDR  = 16'h0100;
  localparam logic [15:0] IPL_WRITE_ADDR = 16'h0200;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } phase_t;

endpackage

// File: rtl/wb_ipl_master.sv
// Wishbone pipelined master: per request, reads one word from the IPL source
// and writes it to the IPL sink inside a single CYC_O cycle.
module wb_ipl_master
  import ipl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] READ_ADDR  = ADDR_WIDTH'(IPL_READ_ADDR),
  parameter logic [ADDR_WIDTH-1:0] WRITE_ADDR = ADDR_WIDTH'(IPL_WRITE_ADDR)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  dreq_i,
  output logic                  dack_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  input  logic                  ack_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o
);

  phase_t                  phase_reg, phase_next;
  logic                    stb_next;
  logic                    dack_next;
  logic                    we_next;
  logic                    cyc_next;
  logic [ADDR_WIDTH-1:0]   adr_next;
  logic [DATA_WIDTH-1:0]   dat_next;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      phase_reg <= IDLE;
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      we_o      <= 1'b0;
      dack_o    <= 1'b0;
      adr_o     <= '0;
      dat_o     <= '0;
    end else begin
      phase_reg <= phase_next;
      cyc_o     <= cyc_next;
      stb_o     <= stb_next;
      we_o      <= we_next;
      dack_o    <= dack_next;
      adr_o     <= adr_next;
      dat_o     <= dat_next;
    end
  end

  // ack_i is accepted both in the strobe cycle and in any later wait cycle.
  always_comb begin
    phase_next = phase_reg;
    stb_next   = 1'b0;
    dack_next  = 1'b0;
    dat_next   = dat_o;
    unique case (phase_reg)
      IDLE: begin
        if (dreq_i) begin
          phase_next = RD;
          stb_next   = 1'b1;
          dack_next  = 1'b1;
        end
      end
      RD: begin
        if (ack_i) begin
          phase_next = WR;
          stb_next   = 1'b1;
          dat_next   = dat_i;
        end
      end
      WR: begin
        if (ack_i) begin
          if (dreq_i) begin
            phase_next = RD;
            stb_next   = 1'b1;
            dack_next  = 1'b1;
          end else begin
            phase_next = IDLE;
          end
        end
      end
      default: phase_next = IDLE;
    endcase

    cyc_next = (phase_next != IDLE);
    we_next  = stb_next && (phase_next == WR);
    if (!stb_next)
      adr_next = '0;
    else if (phase_next == WR)
      adr_next = WRITE_ADDR;
    else
      adr_next = READ_ADDR;
  end

endmodule

// File: tb/tb_wb_ipl_master.sv
// Scoreboard bench for wb_ipl_master: each driven cycle pushes the expected
// bus outputs, which are popped and compared one cycle later.
module tb_wb_ipl_master;
  import ipl_pkg::*;

  localparam logic [15:0] RA = IPL_READ_ADDR;
  localparam logic [15:0] WA = IPL_WRITE_ADDR;

  typedef struct {
    logic        cyc;
    logic        stb;
    logic        we;
    logic        dack;
    logic [15:0] adr;
    logic [15:0] dat;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        dreq_i;
  logic        dack_o;
  logic [15:0] adr_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic        ack_i;
  logic [15:0] dat_i;
  logic [15:0] dat_o;

  int   assert_cnt = 0;
  int   fail_cnt   = 0;
  int   step_cnt   = 0;
  exp_t sb_q[$];

  always #5 clk_i = ~clk_i;

  wb_ipl_master dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .dreq_i  (dreq_i),
    .dack_o  (dack_o),
    .adr_o   (adr_o),
    .cyc_o   (cyc_o),
    .stb_o   (stb_o),
    .we_o    (we_o),
    .ack_i   (ack_i),
    .dat_i   (dat_i),
    .dat_o   (dat_o)
  );

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check_value({tag, ".cyc"},  32'(cyc_o),  32'(e.cyc));
    check_value({tag, ".stb"},  32'(stb_o),  32'(e.stb));
    check_value({tag, ".we"},   32'(we_o),   32'(e.we));
    check_value({tag, ".dack"}, 32'(dack_o), 32'(e.dack));
    check_value({tag, ".adr"},  32'(adr_o),  32'(e.adr));
    check_value({tag, ".dat"},  32'(dat_o),  32'(e.dat));
  endtask

  // Drive one cycle of inputs, push the expected post-edge outputs, then
  // pop and compare after the edge.
  task automatic step(input logic dreq, input logic ack, input logic [15:0] dat,
                      input logic e_cyc, input logic e_stb, input logic e_we,
                      input logic e_dack, input logic [15:0] e_adr, input logic [15:0] e_dat);
    exp_t e;
    exp_t got;
    dreq_i = dreq;
    ack_i  = ack;
    dat_i  = dat;
    e.cyc = e_cyc; e.stb = e_stb; e.we = e_we;
    e.dack = e_dack; e.adr = e_adr; e.dat = e_dat;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    step_cnt++;
    got = sb_q.pop_front();
    check_outputs($sformatf("s%0d", step_cnt), got);
    $display("step %0d: dreq=%0b ack=%0b dat_i=%h -> cyc=%0b stb=%0b we=%0b dack=%0b adr=%h dat_o=%h",
             step_cnt, dreq, ack, dat, cyc_o, stb_o, we_o, dack_o, adr_o, dat_o);
  endtask

  exp_t zero_e;
  logic [15:0] word;
  logic [15:0] last_word;

  initial begin
    reset_i = 1'b0;
    dreq_i  = 1'b0;
    ack_i   = 1'b0;
    dat_i   = 16'h0;
    zero_e.cyc = 0; zero_e.stb = 0; zero_e.we = 0; zero_e.dack = 0;
    zero_e.adr = 16'h0; zero_e.dat = 16'h0;

    repeat (2) @(posedge clk_i);
    #1;
    check_outputs("rst", zero_e);
    @(negedge clk_i);
    reset_i = 1'b1;

    // Idle with no request
    repeat (3) step(0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 16'h0);

    // Single transfer with wait states on both strobes
    step(1, 0, 16'h0,    1, 1, 0, 1, RA,    16'h0);
    step(0, 0, 16'h0,    1, 0, 0, 0, 16'h0, 16'h0);
    step(0, 1, 16'hA5C3, 1, 1, 1, 0, WA,    16'hA5C3);
    step(0, 0, 16'h0,    1, 0, 0, 0, 16'h0, 16'hA5C3);
    step(0, 1, 16'h0,    0, 0, 0, 0, 16'h0, 16'hA5C3);

    // Spurious ack while idle
    step(0, 1, 16'h1234, 0, 0, 0, 0, 16'h0, 16'hA5C3);
    step(0, 1, 16'h5678, 0, 0, 0, 0, 16'h0, 16'hA5C3);

    // Back-to-back words, zero wait states
    last_word = 16'hA5C3;
    for (int k = 0; k < 4; k++) begin
      word = 16'(16'h1111 * (k + 1)) ^ 16'(k << 12);
      step(1, 1, 16'hDEAD, 1, 1, 0, 1, RA, last_word);
      step((k == 3) ? 1'b0 : 1'b1, 1, word, 1, 1, 1, 0, WA, word);
      last_word = word;
    end
    step(0, 1, 16'h0, 0, 0, 0, 0, 16'h0, last_word);

    // Asynchronous reset during the read wait state
    step(1, 0, 16'h0, 1, 1, 0, 1, RA,    last_word);
    step(0, 0, 16'h0, 1, 0, 0, 0, 16'h0, last_word);
    #2 reset_i = 1'b0;
    #1 check_outputs("arst", zero_e);
    $display("async reset mid-cycle: cyc=%0b stb=%0b adr=%h dat_o=%h", cyc_o, stb_o, adr_o, dat_o);
    #2 reset_i = 1'b1;
    step(0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 16'h0);

    // dreq toggling during the read wait state must not restart the read
    step(1, 0, 16'h0,    1, 1, 0, 1, RA,    16'h0);
    step(0, 0, 16'h0,    1, 0, 0, 0, 16'h0, 16'h0);
    step(1, 0, 16'h0,    1, 0, 0, 0, 16'h0, 16'h0);
    step(0, 0, 16'h0,    1, 0, 0, 0, 16'h0, 16'h0);
    step(1, 0, 16'h0,    1, 0, 0, 0, 16'h0, 16'h0);
    step(1, 1, 16'hBEEF, 1, 1, 1, 0, WA,    16'hBEEF);
    step(0, 1, 16'h0,    0, 0, 0, 0, 16'h0, 16'hBEEF);

    check_value("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/wb_ipl_master.md
Name: wb_ipl_master

Overview:
- Minimal Wishbone B.4 pipelined bus master that moves one word per request.
- Each request does two single-beat transactions inside one CYC_O cycle:
  - a read from a fixed IPL source address;
  - a write of the captured word to a fixed IPL sink address.
- Exactly one outstanding strobe at a time: one STB, then one ACK, in that order. No STALL handling is needed.
- Sits between an IPL sequencer (dreq/dack handshake) and the system Wishbone intercon.

Parameters:
- ADDR_WIDTH, 16, width of adr_o.
- DATA_WIDTH, 16, width of dat_i / dat_o.
- READ_ADDR, IPL_READ_ADDR (package constant), address presented during the read strobe.
- WRITE_ADDR, IPL_WRITE_ADDR (package constant), address presented during the write strobe.

Ports:
- clk_i  in  1  single system clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- dreq_i  in  1  transfer request from the sequencer; level-sensitive.
- dack_o  out  1  one-cycle pulse, high in the cycle the read strobe is issued.
- adr_o  out  ADDR_WIDTH  Wishbone address; zero whenever stb_o is low.
- cyc_o  out  1  Wishbone cycle.
- stb_o  out  1  Wishbone strobe.
- we_o  out  1  Wishbone write enable; only high together with stb_o.
- ack_i  in  1  Wishbone acknowledge.
- dat_i  in  DATA_WIDTH  read data; sampled when ack_i terminates the read.
- dat_o  out  DATA_WIDTH  write data; holds the last captured read word.

Behaviour:
- All outputs are registered.
- Reset (reset_i low, asynchronous): phase = IDLE; cyc_o, stb_o, we_o, dack_o = 0; adr_o = 0; dat_o = 0.
- Phase register takes the values IDLE, RD, WR. Transitions on each rising clk_i:
  - IDLE, dreq_i=1 -> RD with stb_o=1, dack_o=1. Otherwise stay IDLE.
  - RD, ack_i=1 -> WR with stb_o=1, and dat_o <= dat_i.
  - RD, ack_i=0 -> RD with stb_o=0 (wait state, cyc_o stays 1).
  - WR, ack_i=1, dreq_i=1 -> RD with stb_o=1, dack_o=1. cyc_o stays high (back-to-back).
  - WR, ack_i=1, dreq_i=0 -> IDLE with cyc_o=0.
  - WR, ack_i=0 -> WR with stb_o=0.
- Output decode:
  - cyc_o = (phase != IDLE).
  - adr_o = READ_ADDR when stb_o and RD; WRITE_ADDR when stb_o and WR; 0 otherwise.
  - we_o = stb_o & (phase==WR).
  - dack_o is high only in a cycle that issues a read strobe.
- ack_i is honoured in the strobe cycle itself as well as in any later wait cycle. Latency is therefore zero wait states for a same-cycle-acking slave.
- ack_i is ignored in IDLE.
- dreq_i is ignored in RD and in WR without ack.
- Throughput with dreq_i and ack_i held high: 2 cycles per word (read strobe, write strobe), repeating with cyc_o never dropping.
- Reset asserted mid-cycle aborts immediately to IDLE with all outputs 0. No bus recovery is attempted.

Decomposition:
- Shared package ipl_pkg: IPL_READ_ADDR, IPL_WRITE_ADDR, the phase enum (IDLE/RD/WR).
- Single flat module; no sub-module warranted.

Test Plan:
- Reset and idle: hold reset_i low, then release with dreq_i=0 -> all outputs 0, adr_o=0 for multiple cycles.
- Single transfer with waits:
  - dreq_i=1 for one cycle -> next cycle cyc=1, stb=1, we=0, adr=READ_ADDR, dack=1.
  - dreq_i=0, ack_i=0 -> cyc=1, stb=0, we=0, adr=0, dack=0.
  - ack_i=1 with dat_i=16'hA5C3 -> cyc=1, stb=1, we=1, adr=WRITE_ADDR, dat_o=16'hA5C3.
  - ack_i=0 -> stb=0, we=0, adr=0.
  - ack_i=1 -> cyc=0.
- Back-to-back: dreq_i=1 and ack_i=1 held -> alternating read/write strobes every cycle, cyc_o constant 1, dack_o pulsing every 2nd cycle. Then drop dreq_i -> write completes and cyc_o falls the cycle after the write ack.
- Spurious ack_i=1 while IDLE -> no outputs change.
- Reset pulse during the RD wait state -> outputs 0 asynchronously, before the next clock edge.
- dreq_i toggled during the RD wait state -> no extra dack_o pulse and no extra read strobe.
